// File: rtl/llc_rsp_merge.sv
// N-channel LLC response merge: per-channel FIFOs drained round-robin into one output register.
// Optional counters enabled by defining LLC_RSP_MERGE_STATS_EN.
module llc_rsp_merge #(
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 2,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch_id
`ifdef LLC_RSP_MERGE_STATS_EN
  ,
  output logic [31:0]              stall_cnt,
  output logic [NUM_CH*16-1:0]     grant_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem    [NUM_CH][FIFO_DEPTH];
  logic [AW-1:0]     rd_ptr [NUM_CH];
  logic [AW-1:0]     wr_ptr [NUM_CH];
  logic [CW-1:0]     cnt    [NUM_CH];

  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] nonempty;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   gnt;
  logic [CH_W-1:0]   rr_nxt;
  logic [CH_W:0]     idx;
  logic [CH_W:0]     nxt;
  logic              gnt_vld;
  logic              load_en;

  always_comb begin
    full     = '0;
    nonempty = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      full[k]     = (cnt[k] == CW'(FIFO_DEPTH));
      nonempty[k] = (cnt[k] != '0);
    end
  end

  // Ready depends only on registered occupancy (and reset), never on out_ready.
  assign in_ready = rst ? '0 : ~full;
  assign push     = in_valid & in_ready;
  assign load_en  = !out_valid || out_ready;

  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = {1'b0, rr_ptr} + (CH_W+1)'(i);
      if (idx >= (CH_W+1)'(NUM_CH))
        idx = idx - (CH_W+1)'(NUM_CH);
      if (!gnt_vld && nonempty[idx[CH_W-1:0]]) begin
        gnt     = idx[CH_W-1:0];
        gnt_vld = 1'b1;
      end
    end
  end

  always_comb begin
    nxt = {1'b0, gnt} + (CH_W+1)'(1);
    if (nxt >= (CH_W+1)'(NUM_CH))
      nxt = '0;
    rr_nxt = nxt[CH_W-1:0];
  end

  always_comb begin
    pop = '0;
    if (load_en && gnt_vld)
      pop[gnt] = 1'b1;
  end

  // Storage carries no reset; validity is tracked by the counts.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CH; k++)
      if (push[k])
        mem[k][wr_ptr[k]] <= in_data[k*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) begin
        rd_ptr[k] <= '0;
        wr_ptr[k] <= '0;
        cnt[k]    <= '0;
      end
      rr_ptr    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch_id <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (push[k])
          wr_ptr[k] <= wr_ptr[k] + AW'(1);
        if (pop[k])
          rd_ptr[k] <= rd_ptr[k] + AW'(1);
        if (push[k] && !pop[k])
          cnt[k] <= cnt[k] + CW'(1);
        else if (!push[k] && pop[k])
          cnt[k] <= cnt[k] - CW'(1);
      end
      if (load_en) begin
        out_valid <= gnt_vld;
        if (gnt_vld) begin
          out_data  <= mem[gnt][rd_ptr[gnt]];
          out_ch_id <= gnt;
          rr_ptr    <= rr_nxt;
        end
      end
    end
  end

`ifdef LLC_RSP_MERGE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      grant_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt != '1)
        stall_cnt <= stall_cnt + 32'd1;
      for (int k = 0; k < NUM_CH; k++)
        if (pop[k])
          grant_cnt[k*16 +: 16] <= grant_cnt[k*16 +: 16] + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_llc_rsp_merge.sv
// Directed self-checking bench for llc_rsp_merge (NUM_CH=2, DATA_W=64, FIFO_DEPTH=2).
// Stats checks run only when LLC_RSP_MERGE_STATS_EN is defined.
module tb_llc_rsp_merge;

  localparam int NUM_CH = 2;
  localparam int DATA_W = 64;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH-1:0]        in_ready;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_data;
  logic [0:0]               out_ch_id;
`ifdef LLC_RSP_MERGE_STATS_EN
  logic [31:0]              stall_cnt;
  logic [NUM_CH*16-1:0]     grant_cnt;
`endif

  int tests = 0;
  int fails = 0;

  llc_rsp_merge #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .FIFO_DEPTH(2)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ch_id(out_ch_id)
`ifdef LLC_RSP_MERGE_STATS_EN
    , .stall_cnt(stall_cnt), .grant_cnt(grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = '0;
    in_data = '0;
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = '0;
    in_data = '0;
    out_ready = 1'b1;
    step();
    step();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL rst_out_valid got %0b want 0", out_valid);
    end
    tests++;
    if (out_data !== 64'd0) begin
      fails++; $display("FAIL rst_out_data got %h want 0", out_data);
    end
    tests++;
    if (out_ch_id !== 1'b0) begin
      fails++; $display("FAIL rst_ch_id got %0d want 0", out_ch_id);
    end
    tests++;
    if (in_ready !== 2'b00) begin
      fails++; $display("FAIL rst_in_ready_low got %b want 00", in_ready);
    end
    rst = 1'b0;
    step();
    tests++;
    if (in_ready !== 2'b11) begin
      fails++; $display("FAIL rst_in_ready_high got %b want 11", in_ready);
    end
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL rst_idle_valid got %0b want 0", out_valid);
    end
  endtask

  task automatic test_single_beat();
    do_reset();
    out_ready = 1'b1;
    in_valid = 2'b10;
    in_data[64 +: 64] = 64'hA5;
    step();
    in_valid = '0;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL single_early got %0b want 0", out_valid);
    end
    step();
    tests++;
    if (out_valid !== 1'b1) begin
      fails++; $display("FAIL single_valid got %0b want 1", out_valid);
    end
    tests++;
    if (out_data !== 64'hA5) begin
      fails++; $display("FAIL single_data got %h want a5", out_data);
    end
    tests++;
    if (out_ch_id !== 1'b1) begin
      fails++; $display("FAIL single_ch got %0d want 1", out_ch_id);
    end
    step();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL single_drain got %0b want 0", out_valid);
    end
  endtask

  task automatic test_fairness();
    logic [1:0] v, r;
    logic [63:0] dq[$];
    logic        cq[$];
    int i0, i1;
    logic [63:0] exp_d;
    do_reset();
    out_ready = 1'b1;
    i0 = 0;
    i1 = 0;
    for (int cyc = 0; cyc < 40 && dq.size() < 8; cyc++) begin
      v[0] = (i0 < 4);
      v[1] = (i1 < 4);
      in_valid = v;
      in_data[0 +: 64] = 64'h100 + 64'(i0);
      in_data[64 +: 64] = 64'h200 + 64'(i1);
      r = in_ready;
      if (out_valid && out_ready) begin
        dq.push_back(out_data);
        cq.push_back(out_ch_id);
      end
      step();
      if (v[0] && r[0]) i0++;
      if (v[1] && r[1]) i1++;
    end
    in_valid = '0;
    tests++;
    if (dq.size() != 8) begin
      fails++; $display("FAIL fair_count got %0d want 8", dq.size());
    end
    for (int j = 0; j < dq.size() && j < 8; j++) begin
      exp_d = ((j % 2) ? 64'h200 : 64'h100) + 64'(j / 2);
      tests++;
      if (cq[j] !== 1'((j % 2)) || dq[j] !== exp_d) begin
        fails++;
        $display("FAIL fair_beat%0d got ch%0d %h want ch%0d %h",
                 j, cq[j], dq[j], j % 2, exp_d);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] dq[$];
    do_reset();
    out_ready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      in_valid = 2'b01;
      in_data[0 +: 64] = 64'hB0 + 64'(b);
      step();
    end
    in_valid = '0;
    tests++;
    if (in_ready[0] !== 1'b0) begin
      fails++; $display("FAIL bp_full_ready got %0b want 0", in_ready[0]);
    end
    for (int c = 0; c < 3; c++) begin
      tests++;
      if (out_valid !== 1'b1 || out_data !== 64'hB0) begin
        fails++;
        $display("FAIL bp_hold%0d got v%0b %h want v1 b0", c, out_valid, out_data);
      end
      step();
    end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 10 && dq.size() < 3; cyc++) begin
      if (out_valid) dq.push_back(out_data);
      step();
    end
    tests++;
    if (dq.size() != 3) begin
      fails++; $display("FAIL bp_count got %0d want 3", dq.size());
    end
    for (int j = 0; j < dq.size(); j++) begin
      tests++;
      if (dq[j] !== 64'hB0 + 64'(j)) begin
        fails++; $display("FAIL bp_order%0d got %h want %h", j, dq[j], 64'hB0 + 64'(j));
      end
    end
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL bp_empty got %0b want 0", out_valid);
    end
  endtask

  task automatic test_wrap();
    logic [63:0] dq[$];
    logic        v, r, orr, ld;
    int          i0, mcnt, bad;
    logic        mout;
    do_reset();
    i0 = 0;
    mcnt = 0;
    mout = 1'b0;
    bad = 0;
    for (int cyc = 0; cyc < 300 && dq.size() < 10; cyc++) begin
      v = (i0 < 10);
      orr = 1'($urandom_range(0, 1));
      in_valid = {1'b0, v};
      in_data[0 +: 64] = 64'hC00 + 64'(i0);
      out_ready = orr;
      r = in_ready[0];
      tests++;
      if (r !== (mcnt != 2)) begin
        fails++; bad++;
        if (bad < 5) $display("FAIL wrap_ready cyc%0d got %0b want %0b", cyc, r, mcnt != 2);
      end
      if (out_valid && orr) dq.push_back(out_data);
      step();
      ld = !mout || orr;
      if (ld) mout = (mcnt > 0);
      mcnt = mcnt + ((v && r) ? 1 : 0) - ((ld && mcnt > 0) ? 1 : 0);
      if (v && r) i0++;
    end
    in_valid = '0;
    tests++;
    if (dq.size() != 10) begin
      fails++; $display("FAIL wrap_count got %0d want 10", dq.size());
    end
    for (int j = 0; j < dq.size(); j++) begin
      tests++;
      if (dq[j] !== 64'hC00 + 64'(j)) begin
        fails++; $display("FAIL wrap_order%0d got %h want %h", j, dq[j], 64'hC00 + 64'(j));
      end
    end
  endtask

  task automatic test_back_to_back();
    int first, last, got;
    logic v, r;
    int i0;
    do_reset();
    out_ready = 1'b1;
    first = -1;
    last = -1;
    got = 0;
    i0 = 0;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      v = (i0 < 4);
      in_valid = {1'b0, v};
      in_data[0 +: 64] = 64'hD0 + 64'(i0);
      r = in_ready[0];
      if (out_valid) begin
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      step();
      if (v && r) i0++;
    end
    in_valid = '0;
    tests++;
    if (got != 4 || last - first != 3) begin
      fails++; $display("FAIL b2b_span got %0d beats span %0d want 4 span 3", got, last - first);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    do_reset();
    out_ready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      in_valid = 2'b10;
      in_data[64 +: 64] = 64'hE0 + 64'(b);
      step();
    end
    in_valid = '0;
    tests++;
    if (out_valid !== 1'b1) begin
      fails++; $display("FAIL mid_pre_valid got %0b want 1", out_valid);
    end
    rst = 1'b1;
    step();
    tests++;
    if (out_valid !== 1'b0 || out_data !== 64'd0 || out_ch_id !== 1'b0) begin
      fails++;
      $display("FAIL mid_rst_out got v%0b %h ch%0d want v0 0 ch0", out_valid, out_data, out_ch_id);
    end
    tests++;
    if (in_ready !== 2'b00) begin
      fails++; $display("FAIL mid_rst_ready got %b want 00", in_ready);
    end
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    tests++;
    if (in_ready !== 2'b11) begin
      fails++; $display("FAIL mid_post_ready got %b want 11", in_ready);
    end
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid) seen++;
      step();
    end
    tests++;
    if (seen != 0) begin
      fails++; $display("FAIL mid_stale got %0d beats want 0", seen);
    end
  endtask

`ifdef LLC_RSP_MERGE_STATS_EN
  task automatic test_stats();
    do_reset();
    tests++;
    if (stall_cnt !== 32'd0 || grant_cnt !== 32'd0) begin
      fails++; $display("FAIL stats_rst got %0d %h want 0 0", stall_cnt, grant_cnt);
    end
    out_ready = 1'b0;
    in_valid = 2'b10;
    in_data[64 +: 64] = 64'hF0;
    step();
    in_valid = '0;
    step();
    for (int c = 0; c < 5; c++) step();
    tests++;
    if (stall_cnt !== 32'd5) begin
      fails++; $display("FAIL stats_stall got %0d want 5", stall_cnt);
    end
    out_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      in_valid = 2'b10;
      in_data[64 +: 64] = 64'hF1 + 64'(b);
      step();
    end
    in_valid = '0;
    for (int c = 0; c < 4; c++) step();
    tests++;
    if (grant_cnt[31:16] !== 16'd3 || grant_cnt[15:0] !== 16'd0) begin
      fails++; $display("FAIL stats_grant got %h want 00030000", grant_cnt);
    end
    tests++;
    if (stall_cnt !== 32'd5) begin
      fails++; $display("FAIL stats_stall_hold got %0d want 5", stall_cnt);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    in_valid = '0;
    in_data = '0;
    out_ready = 1'b0;
    test_reset();
    test_single_beat();
    test_fairness();
    test_backpressure();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
`ifdef LLC_RSP_MERGE_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
